key_decoder: RTL and testbench



---
 rtl/key_decoder.sv | 173 +++++++++++++++++
 tb/tb_key_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_decoder.sv
// key_decoder
//
// Decodes PS/2 scan-code-set-2 bytes into navigation key events. Tracks the
// E0 (extended) and F0 (break) prefixes with a four-state FSM and reports:
//   - a one-cycle, one-hot press pulse for UP/DOWN/LEFT/RIGHT/ENTER/ESC,
//   - a held level for each of those keys,
//   - the last make byte (cleared when that same code is released),
//   - a one-cycle pulse when a prefix sequence is abandoned by timeout.
//
// Ports
//   pclk        in   1  pixel clock; all state on its rising edge
//   rst         in   1  synchronous active-high reset
//   rx_data     in   8  scan-code byte, valid when rx_done=1
//   rx_done     in   1  one-cycle strobe for a new rx_data byte
//   keycode     out  8  last make byte without prefix; 0x00 when none held
//   key         out  6  one-hot press pulse {ESC,ENTER,RIGHT,LEFT,DOWN,UP}
//   key_held    out  6  held level per key, same bit order as key
//   seq_timeout out  1  one-cycle pulse when a prefix sequence times out
//
// All outputs are registered and update on the edge after the rx_done cycle
// that completes a sequence.

module key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 650000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] keycode,
  output logic [5:0] key,
  output logic [5:0] key_held,
  output logic       seq_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntSat  = CntW'(TIMEOUT_CYCLES);

  localparam logic [7:0] CodeExt = 8'hE0;
  localparam logic [7:0] CodeBrk = 8'hF0;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;

  // Event decode for the byte presented this cycle
  logic       is_prefix;
  logic       ext_ctx;
  logic       make_evt;
  logic       break_evt;
  logic [5:0] hit;
  logic [5:0] new_press;
  logic       expire;

  // Maps a code (with its extended flag) onto the one-hot key vector.
  // Extended and plain codes are deliberately disjoint: 5A under E0 is not
  // ENTER, and 75 without E0 is not UP.
  function automatic logic [5:0] key_map(input logic ext, input logic [7:0] code);
    logic [5:0] m;
    m = '0;
    if (ext) begin
      case (code)
        8'h75:   m = 6'b000001; // UP
        8'h72:   m = 6'b000010; // DOWN
        8'h6B:   m = 6'b000100; // LEFT
        8'h74:   m = 6'b001000; // RIGHT
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h5A:   m = 6'b010000; // ENTER
        8'h76:   m = 6'b100000; // ESC
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  always_comb begin
    is_prefix = (rx_data == CodeExt) || (rx_data == CodeBrk);
    ext_ctx   = (state == StExt) || (state == StExtBrk);
    hit       = key_map(ext_ctx, rx_data);

    // A make completes from IDLE or EXT on any non-prefix byte; a break
    // completes from either break state on any byte at all.
    make_evt  = rx_done && !is_prefix && ((state == StIdle) || (state == StExt));
    break_evt = rx_done && ((state == StBrk) || (state == StExtBrk));

    // Only a key that is not already held produces a press pulse, so
    // typematic repeats are silent and key stays at most one-hot.
    new_press = hit & ~key_held;

    // rx_done takes precedence over expiry in the same cycle
    expire    = !rx_done && (state != StIdle) && (cnt == CntLast);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      keycode     <= 8'h00;
      key         <= '0;
      key_held    <= '0;
      seq_timeout <= 1'b0;
    end else begin
      // Pulses default low every cycle
      key         <= '0;
      seq_timeout <= 1'b0;

      if (rx_done) begin
        cnt <= '0;

        unique case (state)
          StIdle: begin
            if (rx_data == CodeExt) begin
              state <= StExt;
            end else if (rx_data == CodeBrk) begin
              state <= StBrk;
            end else begin
              state <= StIdle;
            end
          end
          StExt: begin
            if (rx_data == CodeBrk) begin
              state <= StExtBrk;
            end else if (rx_data == CodeExt) begin
              // Repeated E0 keeps the extended context open
              state <= StExt;
            end else begin
              state <= StIdle;
            end
          end
          StBrk:    state <= StIdle;
          StExtBrk: state <= StIdle;
          default:  state <= StIdle;
        endcase

        if (make_evt) begin
          keycode <= rx_data;
          if (new_press != '0) begin
            key      <= new_press;
            key_held <= key_held | new_press;
          end
        end

        if (break_evt) begin
          key_held <= key_held & ~hit;
          if (rx_data == keycode) begin
            keycode <= 8'h00;
          end
        end
      end else if (state != StIdle) begin
        if (expire) begin
          // Abandon the prefix; key state is left exactly as it was
          state       <= StIdle;
          seq_timeout <= 1'b1;
        end
        if (cnt != CntSat) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_decoder.sv
// Self-checking bench for key_decoder: directed scenarios for the documented
// corner cases followed by random byte traffic, all compared every cycle
// against a byte-queue reference model of the PS/2 sequence rules.

module tb_key_decoder;

  localparam int unsigned T = 20;

  logic       pclk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] keycode;
  logic [5:0] key;
  logic [5:0] key_held;
  logic       seq_timeout;

  int errors;
  int checks;

  key_decoder #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .keycode    (keycode),
    .key        (key),
    .key_held   (key_held),
    .seq_timeout(seq_timeout)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model: pending prefix bytes kept as a queue, age counted in
  // cycles since the last received byte.
  logic [7:0] pend[$];
  int         age;
  logic [7:0] m_kc;
  logic [5:0] m_held;
  logic [5:0] m_key;
  logic       m_to;
  int         press_cnt;

  function automatic int key_idx(input bit ext, input logic [7:0] b);
    if (ext) begin
      if (b == 8'h75) return 0;
      if (b == 8'h72) return 1;
      if (b == 8'h6B) return 2;
      if (b == 8'h74) return 3;
    end else begin
      if (b == 8'h5A) return 4;
      if (b == 8'h76) return 5;
    end
    return -1;
  endfunction

  function automatic bit pend_has(input logic [7:0] b);
    foreach (pend[i]) if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input bit d, input logic [7:0] b);
    bit has_e0;
    bit has_f0;
    int idx;
    m_key = '0;
    m_to  = 1'b0;
    if (r) begin
      pend.delete();
      age    = 0;
      m_kc   = 8'h00;
      m_held = '0;
    end else if (d) begin
      age    = 0;
      has_e0 = pend_has(8'hE0);
      has_f0 = pend_has(8'hF0);
      if (has_f0) begin
        idx = key_idx(has_e0, b);
        if (idx >= 0) m_held[idx] = 1'b0;
        if (b == m_kc) m_kc = 8'h00;
        pend.delete();
      end else if (b == 8'hE0) begin
        pend.delete();
        pend.push_back(8'hE0);
      end else if (b == 8'hF0) begin
        pend.push_back(8'hF0);
      end else begin
        idx  = key_idx(has_e0, b);
        m_kc = b;
        if (idx >= 0 && !m_held[idx]) begin
          m_key[idx]  = 1'b1;
          m_held[idx] = 1'b1;
        end
        pend.delete();
      end
    end else if (pend.size() != 0) begin
      age++;
      if (age == T) begin
        m_to = 1'b1;
        pend.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit r, input bit d, input logic [7:0] b);
    rst     = r;
    rx_done = d;
    rx_data = b;
    model_step(r, d, b);
    @(posedge pclk);
    #1;
    chk("keycode", keycode, m_kc);
    chk("key", {2'b00, key}, {2'b00, m_key});
    chk("key_held", {2'b00, key_held}, {2'b00, m_held});
    chk("seq_timeout", {7'd0, seq_timeout}, {7'd0, m_to});
    if (key[4]) press_cnt++;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] pool[10];
  int         to_seen;

  initial begin
    errors    = 0;
    checks    = 0;
    press_cnt = 0;
    age       = 0;
    m_kc      = 8'h00;
    m_held    = '0;
    m_key     = '0;
    m_to      = 1'b0;
    rst       = 1'b1;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    pool      = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h76, 8'h1C, 8'hE0};

    // Reset state
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h5A);
    chk("reset_keycode", keycode, 8'h00);
    chk("reset_held", {2'b00, key_held}, 8'h00);

    // E0 6B -> LEFT press
    send(8'hE0);
    send(8'h6B);
    chk("left_pulse", {2'b00, key}, 8'h04);
    chk("left_held", {2'b00, key_held}, 8'h04);
    chk("left_code", keycode, 8'h6B);
    idle(1);
    chk("left_pulse_end", {2'b00, key}, 8'h00);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("left_release", {2'b00, key_held}, 8'h00);

    // ENTER with typematic repeats then release
    press_cnt = 0;
    send(8'h5A);
    idle(2);
    send(8'h5A);
    send(8'h5A);
    chk("enter_held_rpt", {7'd0, key_held[4]}, 8'h01);
    send(8'hF0);
    chk("enter_held_mid", {7'd0, key_held[4]}, 8'h01);
    send(8'h5A);
    chk("enter_one_pulse", press_cnt[7:0], 8'h01);
    chk("enter_released", {7'd0, key_held[4]}, 8'h00);
    chk("enter_code_clr", keycode, 8'h00);

    // Timeout after E0; 75 then decodes as plain unmapped make
    send(8'hE0);
    idle(T - 1);
    chk("to_not_yet", {7'd0, seq_timeout}, 8'h00);
    idle(1);
    chk("to_pulse", {7'd0, seq_timeout}, 8'h01);
    send(8'h75);
    chk("to_code", keycode, 8'h75);
    chk("to_no_key", {2'b00, key}, 8'h00);
    chk("to_pulse_end", {7'd0, seq_timeout}, 8'h00);

    // Break of an unheld extended key leaves keycode alone
    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    chk("brk_keep_code", keycode, 8'h1C);
    chk("brk_held", {2'b00, key_held}, 8'h00);

    // Reset mid-sequence discards E0
    send(8'hE0);
    cyc(1'b1, 1'b0, 8'h00);
    send(8'h5A);
    chk("rst_mid_enter", {2'b00, key}, 8'h10);
    chk("rst_mid_no_to", {7'd0, seq_timeout}, 8'h00);

    // Byte on the exact expiry cycle wins over the timeout
    send(8'hF0);
    idle(T - 1);
    send(8'h5A);
    chk("race_no_to", {7'd0, seq_timeout}, 8'h00);
    chk("race_break", {2'b00, key_held}, 8'h00);
    chk("race_code", keycode, 8'h00);

    // Random traffic
    to_seen = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 300) == 0) begin
        cyc(1'b1, $urandom_range(0, 1) == 1, 8'h5A);
      end else if ($urandom_range(0, 40) == 0) begin
        idle(int'($urandom_range(T - 2, T + 2)));
      end else if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 7) == 0) send(8'($urandom));
        else send(pool[$urandom_range(0, 9)]);
      end else begin
        idle(1);
      end
      if (seq_timeout) to_seen++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
